// File: rtl/mio_bus_ws.sv
// Memory-mapped I/O bus controller: decodes one of 2^SEL_W slaves from the upper
// address bits, stalls the master until that slave answers, and aborts on timeout.
module mio_bus_ws #(
  parameter int                 DATA_W   = 32,
  parameter int                 ADDR_W   = 32,
  parameter int                 SEL_W    = 3,
  parameter int                 TIMEOUT  = 15,
  parameter logic [DATA_W-1:0]  ERR_DATA = 32'hDEAD_BEEF,
  localparam int                N_SLV    = 1 << SEL_W,
  localparam int                OFF_W    = ADDR_W - SEL_W
) (
  input  logic                    clk,
  input  logic                    clrn,
  input  logic [ADDR_W-1:0]       m_addr,
  input  logic [DATA_W-1:0]       m_wdata,
  input  logic                    m_we,
  input  logic                    m_re,
  output logic [DATA_W-1:0]       m_rdata,
  output logic                    m_stall,
  output logic [OFF_W-1:0]        s_addr,
  output logic [DATA_W-1:0]       s_wdata,
  output logic [N_SLV-1:0]        s_sel,
  output logic                    s_we,
  output logic                    s_re,
  input  logic [N_SLV*DATA_W-1:0] s_rdata,
  input  logic [N_SLV-1:0]        s_ready,
  output logic                    err_flag,
  output logic [ADDR_W-1:0]       err_addr,
  input  logic                    err_clr
);

  localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {ST_IDLE, ST_ACCESS, ST_DONE} state_t;

  state_t             r_state;
  state_t             w_next;
  logic [CNT_W-1:0]   r_cnt;
  logic [SEL_W-1:0]   r_idx;
  logic [ADDR_W-1:0]  r_addr;
  logic               r_we;

  logic               w_req;
  logic               w_ready;
  logic               w_tmo;
  logic [SEL_W-1:0]   w_idx;
  logic [DATA_W-1:0]  w_slice;

  assign w_req   = m_we | m_re;
  assign w_idx   = m_addr[ADDR_W-1:OFF_W];
  assign w_ready = s_ready[r_idx];
  assign w_tmo   = (r_cnt == CNT_W'(TIMEOUT - 1));
  assign w_slice = s_rdata[r_idx*DATA_W +: DATA_W];
  assign s_addr  = r_addr[OFF_W-1:0];

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) r_state <= ST_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:   if (w_req) w_next = ST_ACCESS;
      ST_ACCESS: if (w_ready || w_tmo) w_next = ST_DONE;
      ST_DONE:   w_next = ST_IDLE;
      default:   w_next = ST_IDLE;
    endcase
  end

  always_comb begin
    m_stall = 1'b0;
    case (r_state)
      ST_IDLE:   m_stall = w_req;
      ST_ACCESS: m_stall = 1'b1;
      default:   m_stall = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      r_cnt    <= '0;
      r_idx    <= '0;
      r_addr   <= '0;
      r_we     <= 1'b0;
      s_wdata  <= '0;
      s_sel    <= '0;
      s_we     <= 1'b0;
      s_re     <= 1'b0;
      m_rdata  <= '0;
      err_flag <= 1'b0;
      err_addr <= '0;
    end else begin
      // Abort below is assigned later, so it overrides a same-edge clear.
      if (err_clr) err_flag <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_req) begin
            r_addr  <= m_addr;
            s_wdata <= m_wdata;
            r_we    <= m_we;
            r_idx   <= w_idx;
            s_sel   <= N_SLV'(1) << w_idx;
            s_we    <= m_we;
            s_re    <= ~m_we;
            r_cnt   <= '0;
          end
        end
        ST_ACCESS: begin
          if (w_ready) begin
            if (!r_we) m_rdata <= w_slice;
            s_sel <= '0;
            s_we  <= 1'b0;
            s_re  <= 1'b0;
          end else if (w_tmo) begin
            if (!r_we) m_rdata <= ERR_DATA;
            s_sel    <= '0;
            s_we     <= 1'b0;
            s_re     <= 1'b0;
            err_flag <= 1'b1;
            err_addr <= r_addr;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mio_bus_ws.sv
// Bench for mio_bus_ws: table of accesses plus hand sequences for timeout,
// error clear and asynchronous reset, checked through an expectation queue.
module tb_mio_bus_ws;

  localparam int DATA_W  = 32;
  localparam int ADDR_W  = 32;
  localparam int SEL_W   = 3;
  localparam int TIMEOUT = 15;
  localparam int N_SLV   = 8;
  localparam int OFF_W   = 29;

  logic                    clk = 1'b0;
  logic                    clrn;
  logic [ADDR_W-1:0]       m_addr;
  logic [DATA_W-1:0]       m_wdata;
  logic                    m_we, m_re;
  logic [DATA_W-1:0]       m_rdata;
  logic                    m_stall;
  logic [OFF_W-1:0]        s_addr;
  logic [DATA_W-1:0]       s_wdata;
  logic [N_SLV-1:0]        s_sel;
  logic                    s_we, s_re;
  logic [N_SLV*DATA_W-1:0] s_rdata;
  logic [N_SLV-1:0]        s_ready;
  logic                    err_flag;
  logic [ADDR_W-1:0]       err_addr;
  logic                    err_clr;

  mio_bus_ws #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .SEL_W(SEL_W), .TIMEOUT(TIMEOUT),
               .ERR_DATA(32'hDEAD_BEEF)) dut (
    .clk(clk), .clrn(clrn), .m_addr(m_addr), .m_wdata(m_wdata), .m_we(m_we),
    .m_re(m_re), .m_rdata(m_rdata), .m_stall(m_stall), .s_addr(s_addr),
    .s_wdata(s_wdata), .s_sel(s_sel), .s_we(s_we), .s_re(s_re), .s_rdata(s_rdata),
    .s_ready(s_ready), .err_flag(err_flag), .err_addr(err_addr), .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic        re;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          k;      // ACCESS cycle in which ready rises; 0 = never
    logic [7:0]  stray;  // ready bits of other slaves held during ACCESS
    int          clr_c;  // ACCESS cycle in which err_clr is pulsed; 0 = none
  } vec_t;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    logic [31:0] eaddr;
    int          stall;
    int          nwe;
    int          nre;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] slv_data [N_SLV];
  logic [31:0] mdl_rdata;
  logic        mdl_err;
  logic [31:0] mdl_eaddr;
  int          n_total = 0;
  int          n_pass  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic model_reset();
    mdl_rdata = '0;
    mdl_err   = 1'b0;
    mdl_eaddr = '0;
  endtask

  task automatic run_access(input vec_t v);
    exp_t        e;
    exp_t        got;
    logic        wr;
    logic [2:0]  idx;
    logic [7:0]  sel_exp;
    bit          abort;
    bit          done;
    int          nstall, nwe, nre;
    @(negedge clk);
    wr      = v.we;
    idx     = v.addr[31:29];
    sel_exp = 8'h01 << idx;
    abort   = (v.k == 0) || (v.k > TIMEOUT);
    if (v.clr_c > 0) mdl_err = 1'b0;
    if (abort) begin
      if (!wr) mdl_rdata = 32'hDEAD_BEEF;
      mdl_err   = 1'b1;
      mdl_eaddr = v.addr;
    end else if (!wr) begin
      mdl_rdata = slv_data[idx];
    end
    e.rdata = mdl_rdata;
    e.err   = mdl_err;
    e.eaddr = mdl_eaddr;
    e.stall = (abort ? TIMEOUT : v.k) + 1;
    e.nwe   = wr ? e.stall - 1 : 0;
    e.nre   = wr ? 0 : e.stall - 1;
    sb.push_back(e);

    m_addr  = v.addr;
    m_wdata = v.wdata;
    m_we    = v.we;
    m_re    = v.re;
    s_ready = '0;
    #1;
    nstall = m_stall ? 1 : 0;
    nwe = 0;
    nre = 0;
    done = 0;
    for (int c = 1; c <= 40 && !done; c++) begin
      @(negedge clk);
      if (!m_stall) begin
        done = 1;
      end else begin
        nstall++;
        if (s_we) nwe++;
        if (s_re) nre++;
        if (c == 1) begin
          check("s_sel", 64'(s_sel), 64'(sel_exp));
          check("s_addr", 64'(s_addr), 64'(v.addr[28:0]));
          if (wr) check("s_wdata", 64'(s_wdata), 64'(v.wdata));
        end
        s_ready = v.stray & ~sel_exp;
        if (c == v.k) s_ready[idx] = 1'b1;
        err_clr = (c == v.clr_c);
      end
    end
    s_ready = '0;
    err_clr = 1'b0;
    m_we    = 1'b0;
    m_re    = 1'b0;
    got = sb.pop_front();
    check("done_seen", 64'(done), 64'(1));
    check("m_rdata", 64'(m_rdata), 64'(got.rdata));
    check("err_flag", 64'(err_flag), 64'(got.err));
    check("err_addr", 64'(err_addr), 64'(got.eaddr));
    check("stall_cycles", 64'(nstall), 64'(got.stall));
    check("s_we_cycles", 64'(nwe), 64'(got.nwe));
    check("s_re_cycles", 64'(nre), 64'(got.nre));
    check("s_sel_done", 64'(s_sel), 64'(0));
  endtask

  vec_t vt[6];

  initial begin
    vec_t v;
    for (int i = 0; i < N_SLV; i++) slv_data[i] = 32'hC0DE_0000 + 32'(i * 32'h111);
    slv_data[3] = 32'h1234_5678;
    for (int i = 0; i < N_SLV; i++) s_rdata[i*DATA_W +: DATA_W] = slv_data[i];
    clrn = 1'b0; m_addr = '0; m_wdata = '0; m_we = 1'b0; m_re = 1'b0;
    s_ready = '0; err_clr = 1'b0;
    model_reset();

    vt[0] = '{we:1'b0, re:1'b1, addr:32'h6000_0004, wdata:32'h0,          k:1, stray:8'h00, clr_c:0};
    vt[1] = '{we:1'b1, re:1'b0, addr:32'h2000_0010, wdata:32'hA5A5_0001, k:4, stray:8'h00, clr_c:0};
    vt[2] = '{we:1'b1, re:1'b1, addr:32'hC000_0100, wdata:32'h0BAD_F00D, k:2, stray:8'h04, clr_c:0};
    vt[3] = '{we:1'b0, re:1'b1, addr:32'hC000_0008, wdata:32'h0,          k:3, stray:8'h04, clr_c:0};
    vt[4] = '{we:1'b0, re:1'b1, addr:32'h0000_0ABC, wdata:32'h0,          k:3, stray:8'hFF, clr_c:0};
    vt[5] = '{we:1'b1, re:1'b0, addr:32'hFFFF_FFFC, wdata:32'h7777_0007, k:1, stray:8'h00, clr_c:0};

    #12;
    check("rst_m_rdata", 64'(m_rdata), 64'(0));
    check("rst_s_sel", 64'(s_sel), 64'(0));
    check("rst_strobes", 64'({s_we, s_re}), 64'(0));
    check("rst_err", 64'({err_flag, err_addr}), 64'(0));
    check("rst_s_addr_wdata", 64'({s_addr, s_wdata}), 64'(0));
    check("rst_stall", 64'(m_stall), 64'(0));
    @(negedge clk);
    clrn = 1'b1;

    for (int i = 0; i < 6; i++) run_access(vt[i]);

    // Timeout read of slave 5, then clear the flag while idle.
    v = '{we:1'b0, re:1'b1, addr:32'hA000_0020, wdata:32'h0, k:0, stray:8'h00, clr_c:0};
    run_access(v);
    @(negedge clk);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    mdl_err = 1'b0;
    check("err_clr_flag", 64'(err_flag), 64'(0));
    check("err_clr_addr_hold", 64'(err_addr), 64'(32'hA000_0020));

    // Ready on the final ACCESS cycle beats the timeout.
    v = '{we:1'b0, re:1'b1, addr:32'hA000_0024, wdata:32'h0, k:TIMEOUT, stray:8'h00, clr_c:0};
    run_access(v);

    // Abort and err_clr on the same edge: abort wins.
    v = '{we:1'b1, re:1'b0, addr:32'h8000_0040, wdata:32'h1, k:0, stray:8'h00, clr_c:TIMEOUT};
    run_access(v);

    // Clear during a later normal access.
    v = '{we:1'b0, re:1'b1, addr:32'h4000_0000, wdata:32'h0, k:2, stray:8'h00, clr_c:1};
    run_access(v);

    // Asynchronous reset in the middle of a waiting access.
    @(negedge clk);
    m_addr = 32'h8000_0000;
    m_re   = 1'b1;
    repeat (5) @(negedge clk);
    check("pre_rst_s_re", 64'(s_re), 64'(1));
    #2;
    clrn = 1'b0;
    #1;
    check("midrst_s_sel", 64'(s_sel), 64'(0));
    check("midrst_strobes", 64'({s_we, s_re}), 64'(0));
    check("midrst_m_rdata", 64'(m_rdata), 64'(0));
    check("midrst_err", 64'({err_flag, err_addr}), 64'(0));
    m_re = 1'b0;
    #1;
    check("midrst_idle", 64'(m_stall), 64'(0));
    model_reset();
    @(negedge clk);
    clrn = 1'b1;
    v = '{we:1'b0, re:1'b1, addr:32'h6000_0000, wdata:32'h0, k:2, stray:8'h00, clr_c:0};
    run_access(v);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
